sfetch_buffer: RTL
==================

// Module: sfetch_buffer
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined core: owns the fetch PC,
//  issues pipelined requests to instruction memory over a valid/ready channel and holds
//  returned instructions in a DEPTH-entry prefetch queue. Decode drains the queue over
//  valid/ready. A redirect (branch/jump resolved in EX/MEM) flushes the queue and
//  discards all in-flight responses. Adds variable memory latency and backpressure.
// PARAMETERS
//  ADDR_WIDTH  32      fetch address / PC width
//  DATA_WIDTH  32      instruction word width
//  DEPTH       4       prefetch queue entries; power of 2, >=2
//  RESET_PC    '0      first fetch address after reset
// PORTS
//  clk              in   1                clock, rising edge
//  rst              in   1                async reset, active-high
//  redirect_i       in   1                flush + restart fetch at redirect_pc_i
//  redirect_pc_i    in   ADDR_WIDTH       new fetch PC; bits[1:0] ignored (forced 0)
//  imem_req_valid_o out  1                request valid
//  imem_req_ready_i in   1                memory accepts request
//  imem_req_addr_o  out  ADDR_WIDTH       request address (word aligned)
//  imem_rsp_valid_i in   1                response valid; in order, always accepted
//  imem_rsp_data_i  in   DATA_WIDTH       response instruction word
//  instr_valid_o    out  1                queue head valid
//  instr_ready_i    in   1                decode accepts head (low = stall)
//  instr_o          out  DATA_WIDTH       head instruction
//  instr_pc_o       out  ADDR_WIDTH       PC of head instruction
//  count_o          out  $clog2(DEPTH+1)  current queue occupancy
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, rsp_pc=RESET_PC; queue empty; outstanding=0, drop_cnt=0;
//   all outputs 0 (imem_req_addr_o=RESET_PC). Reset mid-operation abandons everything;
//   memory is reset with the core, so no stale responses are expected.
//  Request: imem_req_valid_o = !redirect_i && (count + outstanding + drop_cnt) < DEPTH.
//   imem_req_addr_o = fetch_pc. On handshake: fetch_pc += 4 (wraps mod 2^ADDR_WIDTH),
//   outstanding += 1. Credit rule guarantees the queue never overflows.
//  Response: each imem_rsp_valid_i retires one outstanding (or one drop_cnt if nonzero).
//   If drop_cnt==0 and !redirect_i: push {rsp_pc, data}, rsp_pc += 4. Else discard.
//  Drain: pop on instr_valid_o && instr_ready_i. instr_valid_o = !empty (registered).
//   Push and pop in same cycle: count unchanged. Pop while empty: no effect.
//  Redirect (single cycle, priority over all else): queue cleared, count=0;
//   fetch_pc = rsp_pc = {redirect_pc_i[ADDR_WIDTH-1:2],2'b00}; no request issued;
//   drop_cnt <= drop_cnt + outstanding - rsp_valid_i (responses still owed); outstanding=0.
//   A response arriving in the redirect cycle is discarded. A pop in that cycle is
//   ignored (decode flushes too). First new request issues the following cycle.
//  Back-to-back redirects: drop_cnt accumulates; no request until redirect_i drops.
//  Latency: response -> instr_valid_o = 1 cycle (queue empty, no bypass).
// CONFIGURATION
//  SFETCH_BYPASS_EN defined: when queue empty, drop_cnt==0, !redirect_i and response
//   valid, instr_valid_o/instr_o/instr_pc_o driven combinationally from the response;
//   if instr_ready_i is high it is consumed without a push (0-cycle latency).
//  Undefined: no combinational path memory -> decode; strict 1-cycle latency.
// STRUCTURE
//  Package sfetch_pkg: INSTR_BYTES=4, fetch_entry_t struct {pc, instr}, credit-count
//   width function.
//  Sub-module sfetch_fifo: generic sync FIFO of fetch_entry_t with flush, count, DEPTH
//   param. Top holds PC regs, outstanding/drop counters, credit logic, optional bypass.
// TESTING
//  1 Reset release, imem_req_ready_i=1, 1-cycle mem, instr_ready_i=1 -> requests to
//    0x0,0x4,0x8...; instr_pc_o sequence 0x0,0x4,0x8 with one-per-cycle throughput.
//  2 instr_ready_i=0 for 10 cycles, DEPTH=4 -> count_o saturates at 4,
//    imem_req_valid_o low; no word lost or duplicated after release.
//  3 Redirect to 0x103 with 2 outstanding, mem latency 3 -> next request addr 0x100;
//    the 2 late responses dropped; first instr_pc_o after redirect = 0x100.
//  4 Redirect in same cycle as response and pop -> response discarded, count_o=0 next.
//  5 fetch_pc near 0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap).
//  6 SFETCH_BYPASS_EN, queue empty, response + instr_ready_i=1 -> instr_valid_o same
//    cycle, count_o stays 0; without macro, instr_valid_o one cycle later.

Source files
------------

// File: rtl/sfetch_pkg.sv
// Shared types and helpers for the sfetch_buffer instruction-fetch front end.
// Optional macro SFETCH_BYPASS_EN (see sfetch_buffer.sv) does not affect this package.
package sfetch_pkg;

    localparam int INSTR_BYTES        = 4;
    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] pc;
        logic [DEFAULT_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Width able to hold any credit count from 0 to depth inclusive.
    function automatic int creditWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sfetch_fifo.sv
// Generic synchronous FIFO of fetch entries with single-cycle flush and occupancy count.
// Flush has priority over push and pop; pop while empty is ignored.
module sfetch_fifo
    import sfetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = creditWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        data_i,
    input  logic          pop_i,
    output entry_t        data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            doPush, doPop, full;

    assign full   = (count_q == CW'(DEPTH));
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && (!full || doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o  = mem_q[rdPtr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/sfetch_buffer.sv
// Instruction-fetch front end: fetch PC, credit-limited imem requests, prefetch queue, redirect flush.
// Define SFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module sfetch_buffer
    import sfetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    localparam int                   CW         = creditWidth(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic [CW-1:0]         count_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    localparam int SW = CW + 2;

    logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
    logic [ADDR_WIDTH-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         dropCnt_q, dropCnt_d;
    logic                  active_q;

    logic [ADDR_WIDTH-1:0] alignedPc;
    logic                  unusedPcBits;
    logic [SW-1:0]         inFlight;
    logic                  reqFire, rspKeep, rspRetire;
    logic                  bypassValid, bypassTaken;
    logic                  queuePush, queuePop, queueValid;
    entry_t                pushEntry, headEntry;
    logic [CW-1:0]         queueCount;

    assign alignedPc    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign unusedPcBits = ^redirect_pc_i[1:0];

    // Every queue slot is reserved by an occupied entry, a live request or a response owed to a flush.
    assign inFlight = SW'(queueCount) + SW'(outstanding_q) + SW'(dropCnt_q);

    assign imem_req_valid_o = active_q && !redirect_i && (inFlight < SW'(DEPTH));
    assign imem_req_addr_o  = fetchPc_q;
    assign reqFire          = imem_req_valid_o && imem_req_ready_i;

    assign rspRetire = imem_rsp_valid_i && (dropCnt_q == '0);
    assign rspKeep   = rspRetire && !redirect_i;

`ifdef SFETCH_BYPASS_EN
    assign bypassValid = rspKeep && !queueValid;
`else
    assign bypassValid = 1'b0;
`endif
    assign bypassTaken = bypassValid && instr_ready_i;

    assign queuePush       = rspKeep && !bypassTaken;
    assign queuePop        = queueValid && instr_ready_i && !redirect_i;
    assign pushEntry.pc    = rspPc_q;
    assign pushEntry.instr = imem_rsp_data_i;

    sfetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (queuePush),
        .data_i  (pushEntry),
        .pop_i   (queuePop),
        .data_o  (headEntry),
        .valid_o (queueValid),
        .count_o (queueCount)
    );

`ifdef SFETCH_BYPASS_EN
    assign instr_valid_o = queueValid || bypassValid;
    assign instr_o       = bypassValid ? imem_rsp_data_i : headEntry.instr;
    assign instr_pc_o    = bypassValid ? rspPc_q : headEntry.pc;
`else
    assign instr_valid_o = queueValid;
    assign instr_o       = headEntry.instr;
    assign instr_pc_o    = headEntry.pc;
`endif
    assign count_o = queueCount;

    // A redirect converts every live request into a response to be dropped, minus one arriving now.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        outstanding_d = outstanding_q;
        dropCnt_d     = dropCnt_q;
        if (redirect_i) begin
            fetchPc_d     = alignedPc;
            rspPc_d       = alignedPc;
            outstanding_d = '0;
            dropCnt_d     = dropCnt_q + outstanding_q - CW'(imem_rsp_valid_i);
        end else begin
            if (reqFire) fetchPc_d = fetchPc_q + ADDR_WIDTH'(INSTR_BYTES);
            if (rspKeep) rspPc_d = rspPc_q + ADDR_WIDTH'(INSTR_BYTES);
            if (imem_rsp_valid_i && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CW'(1);
            outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspRetire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
            active_q      <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
            active_q      <= 1'b1;
        end
    end

endmodule
